// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control unit for the multicycle RV32I core.
//
// Sequences the shared memory, the ALU and the IR/PC/ALUOut/Data registers
// over 3-5 cycles per instruction (lw 5; sw, R, I, jal 4; beq/bne 3).
// Supports lw, sw, R-type (add sub and or slt xor sll), I-type ALU
// (addi andi ori slti xori), beq, bne, jal. Unknown opcodes park the FSM in
// ERROR until reset.
//
// Optional build macro: MC_PERF_CNT_EN adds the CNT_WIDTH parameter and the
// cycle_cnt / instret performance counters. Without it those are absent.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset (forces FETCH)
//   op, funct3,      instruction fields from the IR
//   funct7b5
//   zero             ALU zero flag (branch resolution)
//   pc_write         PC enable (PCUpdate | taken branch)
//   adr_src          memory address select: 0=PC, 1=Result
//   mem_write        memory write strobe
//   ir_write         IR / OldPC enable
//   result_src       00=ALUOut, 01=Data, 10=ALUResult
//   alu_src_a        00=PC, 01=OldPC, 10=rs1
//   alu_src_b        00=rs2, 01=ImmExt, 10=constant 4
//   imm_src          00=I, 01=S, 10=B, 11=J
//   reg_write        register file write enable
//   alu_control      000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll
//   illegal          high while in ERROR
//   state_o          current state encoding (debug)
//   cycle_cnt,       performance counters (MC_PERF_CNT_EN only)
//   instret

module multicycle_ctrl
`ifdef MC_PERF_CNT_EN
#(
    parameter int unsigned CNT_WIDTH = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;

    // Async reset puts the FSM in FETCH at once, so any mem_write/reg_write
    // decoded from a later state drops the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state_o = r_state;

    // Next state and Moore outputs.
    always_comb begin
        w_next      = S_ERROR;
        w_alu_op    = 2'b00;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write   = 1'b0;
        illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_write    = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jal target is computed here into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default:           w_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                w_alu_op  = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_alu_op  = 2'b10;
                w_next    = S_ALUWB;
            end
            S_JAL: begin
                // PC <= ALUOut (target); ALU computes OldPC+4 for the link.
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                w_alu_op  = 2'b01;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ERROR: begin
                illegal = 1'b1;
                w_next  = S_ERROR;
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    // funct3[0] distinguishes bne from beq, so it flips the sense of zero.
    assign pc_write = w_pc_update | (w_branch & (zero ^ funct3[0]));

    always_comb begin
        alu_control = 3'b000;
        case (w_alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    3'b100:  alu_control = 3'b100;
                    3'b001:  alu_control = 3'b110;
                    default: alu_control = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instret;

    // Every retiring state goes to FETCH unconditionally, so being in one
    // of them is the same as transitioning into FETCH from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else if (r_state != S_ERROR) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            if (r_state == S_MEMWB || r_state == S_MEMWRITE ||
                r_state == S_ALUWB || r_state == S_BRANCH) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [3:0] cycle_cnt, instret;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

`ifdef MC_PERF_CNT_EN
    multicycle_ctrl #(.CNT_WIDTH(4)) dut (
`else
    multicycle_ctrl dut (
`endif
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
        .alu_control(alu_control), .illegal(illegal), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
    );

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, imm_src, reg_write, alu_control, illegal}
    logic [16:0] w_outs;
    assign w_outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                     alu_src_a, alu_src_b, imm_src, reg_write, alu_control,
                     illegal};

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [3:0]  st;
        logic [16:0] outs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z,
                       input logic [3:0] st, input logic [16:0] outs);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st; v.outs = outs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    localparam logic [16:0] E_ERR = 17'b0_0_0_0_00_00_00_00_0_000_1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // lw x6,-4(x9): 0,1,2,3,4
        add(7'b0000011, 3'b010, 1'b1, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0000011, 3'b010, 1'b1, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0000011, 3'b010, 1'b1, 1'b0, 4'd2, 17'b0_0_0_0_00_10_01_00_0_000_0);
        add(7'b0000011, 3'b010, 1'b1, 1'b0, 4'd3, 17'b0_1_0_0_00_00_00_00_0_000_0);
        add(7'b0000011, 3'b010, 1'b1, 1'b0, 4'd4, 17'b0_0_0_0_01_00_00_00_1_000_0);
        // sw: 0,1,2,5
        add(7'b0100011, 3'b010, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_01_0_000_0);
        add(7'b0100011, 3'b010, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_01_0_000_0);
        add(7'b0100011, 3'b010, 1'b0, 1'b0, 4'd2, 17'b0_0_0_0_00_10_01_01_0_000_0);
        add(7'b0100011, 3'b010, 1'b0, 1'b0, 4'd5, 17'b0_1_1_0_00_00_00_01_0_000_0);
        // sub: 0,1,6,7
        add(7'b0110011, 3'b000, 1'b1, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0110011, 3'b000, 1'b1, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0110011, 3'b000, 1'b1, 1'b0, 4'd6, 17'b0_0_0_0_00_10_00_00_0_001_0);
        add(7'b0110011, 3'b000, 1'b1, 1'b0, 4'd7, 17'b0_0_0_0_00_00_00_00_1_000_0);
        // xor (funct3=100, funct7b5=1)
        add(7'b0110011, 3'b100, 1'b1, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0110011, 3'b100, 1'b1, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0110011, 3'b100, 1'b1, 1'b0, 4'd6, 17'b0_0_0_0_00_10_00_00_0_100_0);
        add(7'b0110011, 3'b100, 1'b1, 1'b0, 4'd7, 17'b0_0_0_0_00_00_00_00_1_000_0);
        // sll (funct3=001, funct7b5=1)
        add(7'b0110011, 3'b001, 1'b1, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0110011, 3'b001, 1'b1, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0110011, 3'b001, 1'b1, 1'b0, 4'd6, 17'b0_0_0_0_00_10_00_00_0_110_0);
        add(7'b0110011, 3'b001, 1'b1, 1'b0, 4'd7, 17'b0_0_0_0_00_00_00_00_1_000_0);
        // addi with Instr[30]=1 (negative imm): must stay add
        add(7'b0010011, 3'b000, 1'b1, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0010011, 3'b000, 1'b1, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0010011, 3'b000, 1'b1, 1'b0, 4'd8, 17'b0_0_0_0_00_10_01_00_0_000_0);
        add(7'b0010011, 3'b000, 1'b1, 1'b0, 4'd7, 17'b0_0_0_0_00_00_00_00_1_000_0);
        // slti, unsupported funct3=011 -> add
        add(7'b0010011, 3'b010, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0010011, 3'b010, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0010011, 3'b010, 1'b0, 1'b0, 4'd8, 17'b0_0_0_0_00_10_01_00_0_101_0);
        add(7'b0010011, 3'b011, 1'b0, 1'b0, 4'd7, 17'b0_0_0_0_00_00_00_00_1_000_0);
        // beq taken (zero=1)
        add(7'b1100011, 3'b000, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_10_0_000_0);
        add(7'b1100011, 3'b000, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_10_0_000_0);
        add(7'b1100011, 3'b000, 1'b0, 1'b1, 4'd10, 17'b1_0_0_0_00_10_00_10_0_001_0);
        // beq not taken (zero=0)
        add(7'b1100011, 3'b000, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_10_0_000_0);
        add(7'b1100011, 3'b000, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_10_0_000_0);
        add(7'b1100011, 3'b000, 1'b0, 1'b0, 4'd10, 17'b0_0_0_0_00_10_00_10_0_001_0);
        // bne taken (zero=0)
        add(7'b1100011, 3'b001, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_10_0_000_0);
        add(7'b1100011, 3'b001, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_10_0_000_0);
        add(7'b1100011, 3'b001, 1'b0, 1'b0, 4'd10, 17'b1_0_0_0_00_10_00_10_0_001_0);
        // bne not taken (zero=1)
        add(7'b1100011, 3'b001, 1'b0, 1'b1, 4'd0, 17'b1_0_0_1_10_00_10_10_0_000_0);
        add(7'b1100011, 3'b001, 1'b0, 1'b1, 4'd1, 17'b0_0_0_0_00_01_01_10_0_000_0);
        add(7'b1100011, 3'b001, 1'b0, 1'b1, 4'd10, 17'b0_0_0_0_00_10_00_10_0_001_0);
        // jal: 0,1,9,7
        add(7'b1101111, 3'b000, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_11_0_000_0);
        add(7'b1101111, 3'b000, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_11_0_000_0);
        add(7'b1101111, 3'b000, 1'b0, 1'b0, 4'd9, 17'b1_0_0_0_00_01_10_11_0_000_0);
        add(7'b1101111, 3'b000, 1'b0, 1'b0, 4'd7, 17'b0_0_0_0_00_00_00_11_1_000_0);
        // illegal op 0000000: 0,1,11
        add(7'b0000000, 3'b000, 1'b0, 1'b0, 4'd0, 17'b1_0_0_1_10_00_10_00_0_000_0);
        add(7'b0000000, 3'b000, 1'b0, 1'b0, 4'd1, 17'b0_0_0_0_00_01_01_00_0_000_0);
        add(7'b0000000, 3'b000, 1'b0, 1'b0, 4'd11, E_ERR);

        // Reset state (lw in IR: 0xFFC4A303)
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b1; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_outs", 32'(w_outs), 32'(17'b1_0_0_1_10_00_10_00_0_000_0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; zero = vecs[i].z;
            #1;
            check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d_outs", i), 32'(w_outs), 32'(vecs[i].outs));
            @(negedge clk);
        end

        // ERROR is sticky with every strobe low
        for (int i = 0; i < 20; i++) begin
            op = 7'b0110011; zero = i[0];
            #1;
            check($sformatf("err%0d_state", i), 32'(state_o), 32'd11);
            check($sformatf("err%0d_outs", i), 32'(w_outs), 32'(E_ERR));
            @(negedge clk);
        end

        // Reset asserted mid-MEMWRITE
        reset = 1'b1;
        @(negedge clk);
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sw_memwrite_state", 32'(state_o), 32'd5);
        check("sw_memwrite_strobe", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_memwrite", 32'(mem_write), 32'd0);
        check("rst_mid_state", 32'(state_o), 32'd0);
        @(negedge clk);
        #1;
        check("rst_hold_memwrite", 32'(mem_write), 32'd0);
        check("rst_hold_regwrite", 32'(reg_write), 32'd0);

`ifdef MC_PERF_CNT_EN
        // addi for 17 clocks with CNT_WIDTH=4: cycle_cnt wraps to 1
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("perf_cycle_cnt", 32'(cycle_cnt), 32'd1);
        check("perf_instret", 32'(instret), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit for the multicycle RV32I core; it replaces the single-cycle maindec/aludec pair.
- Sequences one shared memory, one ALU and the IR/PC/ALUOut/Data registers over 3-5 cycles per instruction.
- Sits beside the multicycle datapath. It decodes op/funct3/funct7b5 and drives every mux select and write strobe.
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt, xor, sll), I-type ALU (addi, andi, ori, slti, xori), beq, bne, jal.

Parameters:
- CNT_WIDTH, 32, width of the performance counters. Used only when MC_PERF_CNT_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0] from the IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=Result
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC enable
- result_src  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 register
- alu_src_b  out  2  ALU B select: 00=rs2 register, 01=ImmExt, 10=constant 4
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register file write enable
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll
- illegal  out  1  high while in the ERROR state
- state_o  out  4  current state encoding, for debug
- cycle_cnt  out  CNT_WIDTH  present only with MC_PERF_CNT_EN
- instret  out  CNT_WIDTH  present only with MC_PERF_CNT_EN

Behaviour:
- State register updates on posedge clk. reset forces FETCH asynchronously.
- All outputs are Moore outputs decoded from the state, except:
  - imm_src and alu_control, which also depend on op/funct3/funct7b5.
  - pc_write, which also depends on zero.
- Default value of every strobe and select is 0. No x values are ever driven.
- Values during and immediately after reset follow FETCH: ir_write=1, pc_write=1, alu_src_b=10, result_src=10, illegal=0.
- State encodings, per-state outputs (anything not listed is 0) and transitions:
  - 0 FETCH: ir_write=1, alu_src_b=10, result_src=10, PCUpdate=1, ALUOp=00. Next: DECODE.
  - 1 DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00 (computes branch/jal target into ALUOut). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - any other op -> ERROR
  - 2 MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD if op[5]=0, else MEMWRITE.
  - 3 MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - 4 MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - 5 MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
  - 6 EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Next: ALUWB.
  - 7 ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - 8 EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next: ALUWB.
  - 9 JAL: alu_src_a=01, alu_src_b=10, result_src=00, PCUpdate=1. Next: ALUWB.
  - 10 BRANCH: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, Branch=1. Next: FETCH.
  - 11 ERROR: all strobes 0, illegal=1. Stays in ERROR until reset.
  - Encodings 12-15 go to ERROR on the next clock.
- pc_write = PCUpdate | (Branch & (zero ^ funct3[0])). Branch is taken on beq when zero=1 and on bne when zero=0.
- alu_control decode:
  - ALUOp=00 -> 000; ALUOp=01 -> 001.
  - ALUOp=10 decodes funct3: 000 -> 001 if (op[5] & funct7b5), else 000; 010 -> 101; 110 -> 011; 111 -> 010; 100 -> 100; 001 -> 110.
  - Unsupported funct3 (011, 101) -> 000. No trap is raised.
- imm_src by op: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all others -> 00.
- Cycles per instruction, counting FETCH: lw 5; sw, R, I, jal 4 each; beq/bne 3.
- Reset asserted mid-instruction: FETCH immediately. No pending mem_write or reg_write may be issued after reset rises.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every clock while not in reset.
  - instret increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Both clear to 0 on reset, wrap modulo 2^CNT_WIDTH, and freeze in ERROR.
- Not defined: both ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Release reset, IR=lw x6,-4(x9) (0xFFC4A303) -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4; adr_src=1 in state 3.
- sw (op 0100011) -> sequence 0,1,2,5,0; mem_write=1 exactly one cycle; imm_src=01 throughout.
- R-type op 0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR. Same with funct3=100 -> 100. Same with funct3=001 -> 110. Each retires in 4 cycles.
- Branch sequence, op=1100011:
  - funct3=000, zero=1 in BRANCH -> pc_write=1; zero=0 -> pc_write=0.
  - funct3=001, zero=0 -> pc_write=1.
  - jal -> pc_write=1 in JAL, then reg_write=1 in ALUWB.
- op=0000000 -> ERROR after DECODE; illegal=1, all strobes 0 for 20 cycles. Assert reset mid-MEMWRITE -> mem_write drops immediately and state_o=0.
- With MC_PERF_CNT_EN and CNT_WIDTH=4, run addi repeatedly for 17 cycles -> cycle_cnt wraps to 1; instret=4.
